// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: radix-2 shift-add unsigned multiplier owning the HI/LO
// registers for MULTU / MFHI / MFLO. One partial product per clock, WIDTH
// clocks per product, with a stall request to freeze IF/ID/EX while pending.
module multu_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;

  // The accumulator LSB is shifted out every iteration and never read.
  logic                 unused_acc_lsb;
  assign unused_acc_lsb = acc_q[0];

  // One shift-add step: add multiplicand into upper half (carry kept), shift right.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_next = {sum, acc_q[WIDTH-1:1]};
  end

  // Next-state and datapath control for IDLE / RUN / DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = acc_next[2*WIDTH-1:WIDTH];
          lo_d    = acc_next[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any product in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status decoded from registered state; stall holds MULTU/MFHI/MFLO in EX.
  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    stall = busy & (start | rd_hilo);
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed testbench for multu_hilo_unit with hand-computed expected products.
module tb_multu_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         rd_hilo = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  multu_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_hilo (rd_hilo),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Independent count of done pulses seen at clock edges.
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present start with operands for one edge; optionally keep start high.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) until done is observed; n = edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int n;
    int dc;
    int stall_bad;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_hi",    {32'd0, hi},    64'd0);
    check("rst_lo",    {32'd0, lo},    64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 3 * 5, latency and single done pulse
    dc = done_cnt;
    issue(32'd3, 32'd5, 1'b0);
    check("t1_busy", {63'd0, busy}, 64'd1);
    wait_done(n);
    check("t1_latency", 64'(n), 64'd32);
    check("t1_busy_off", {63'd0, busy}, 64'd0);
    check("t1_hi", {32'd0, hi}, 64'h0);
    check("t1_lo", {32'd0, lo}, 64'hF);
    @(posedge clk);
    #1;
    check("t1_done_off", {63'd0, done}, 64'd0);
    check("t1_pulses", 64'(done_cnt - dc), 64'd1);

    // Max operands, carry path
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(n);
    check("t2_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("t2_lo", {32'd0, lo}, 64'h1);
    @(posedge clk);
    #1;

    // 7 * 9 with MFHI/MFLO held from cycle 5
    issue(32'd7, 32'd9, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rd_hilo = 1'b1;
    #1;
    n = 0;
    stall_bad = 0;
    while (busy === 1'b1 && n < 100) begin
      if (stall !== 1'b1) stall_bad++;
      @(posedge clk);
      #1;
      n++;
    end
    check("t3_stall_run", 64'(stall_bad), 64'd0);
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_stall_done", {63'd0, stall}, 64'd0);
    check("t3_hi", {32'd0, hi}, 64'h0);
    check("t3_lo", {32'd0, lo}, 64'h3F);
    @(posedge clk);
    #1;
    check("t3_stall_idle", {63'd0, stall}, 64'd0);
    rd_hilo = 1'b0;

    // Back-to-back: start held through RUN, second op accepted in DONE
    dc = done_cnt;
    issue(32'h1_0000, 32'h1_0000, 1'b1);
    op_a = 32'd2;
    op_b = 32'd4;
    check("t4_stall_run", {63'd0, stall}, 64'd1);
    wait_done(n);
    check("t4_latency1", 64'(n), 64'd32);
    check("t4_hi1", {32'd0, hi}, 64'h1);
    check("t4_lo1", {32'd0, lo}, 64'h0);
    check("t4_stall_done", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_busy2", {63'd0, busy}, 64'd1);
    check("t4_done_off", {63'd0, done}, 64'd0);
    wait_done(n);
    check("t4_latency2", 64'(n), 64'd32);
    check("t4_hi2", {32'd0, hi}, 64'h0);
    check("t4_lo2", {32'd0, lo}, 64'h8);
    @(posedge clk);
    #1;
    check("t4_pulses", 64'(done_cnt - dc), 64'd2);

    // Reset mid-multiplication aborts it
    dc = done_cnt;
    issue(32'h1234, 32'h5678, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #2;
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_hi", {32'd0, hi}, 64'h0);
    check("t5_lo", {32'd0, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("t5_no_done", 64'(done_cnt - dc), 64'd0);
    check("t5_idle_lo", {32'd0, lo}, 64'h0);
    issue(32'd2, 32'd3, 1'b0);
    wait_done(n);
    check("t5_hi2", {32'd0, hi}, 64'h0);
    check("t5_lo2", {32'd0, lo}, 64'h6);
    @(posedge clk);
    #1;

    // Operand capture: inputs scrambled during RUN
    issue(32'd100, 32'd200, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      op_a = $urandom;
      op_b = $urandom;
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_done", {63'd0, done}, 64'd1);
    check("t6_hi", {32'd0, hi}, 64'h0);
    check("t6_lo", {32'd0, lo}, 64'h4E20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Multi-cycle unsigned multiplier that executes MULTU for the mips_pipeline core.
- It owns the architectural HI/LO registers that MFHI (funct 10) and MFLO (funct 12) read.
- It sits beside the EX stage. EX issues the operands; the unit returns a stall request that the hazard logic uses to freeze IF/ID/EX while a product is pending.
- Radix-2 shift-add, one partial product per clock.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  EX holds a MULTU; qualified with operands this cycle
op_a  input  WIDTH  rs value (multiplicand)
op_b  input  WIDTH  rt value (multiplier)
rd_hilo  input  1  EX holds MFHI or MFLO this cycle
busy  output  1  multiplication in progress
done  output  1  one-cycle pulse: HI/LO just updated
stall  output  1  request pipeline freeze
hi  output  WIDTH  HI register (upper product half)
lo  output  WIDTH  LO register (lower product half)

Behaviour:
- Reset: rst low asynchronously forces state=IDLE, counter=0, multiplicand/accumulator/multiplier shadow regs=0, hi=0, lo=0, busy=0, done=0. Asserting rst mid-multiplication aborts it; no partial result reaches hi/lo.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1, latch op_a into the multiplicand reg, op_b into the multiplier shift reg, clear the 2*WIDTH accumulator, set counter=0, go to RUN.
  - rd_hilo in IDLE is served combinationally from hi/lo, with no stall.
- RUN, each edge:
  - If multiplier[0]=1, add the multiplicand to the upper WIDTH+1 bits of the accumulator. The carry is kept.
  - Shift the accumulator right 1, shift the multiplier right 1, counter+1.
  - On the edge where counter==WIDTH-1 (the WIDTH-th iteration), write the final accumulator to hi (upper) and lo (lower) and go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: if start=1, behave exactly as IDLE+start (back-to-back accepted, zero bubble); else go to IDLE.
- Latency: start sampled at edge E0; hi/lo valid after edge E0+WIDTH (E32 at default); done high during the cycle following that edge.
- busy=1 in RUN only (combinational from state).
- stall=busy & (start | rd_hilo).
  - A new MULTU or an MFHI/MFLO is held in EX until the product commits.
  - The cycle after commit (DONE), stall=0 and rd_hilo reads the new values.
  - start while busy is ignored by the datapath; the stalled instruction re-presents start and is accepted in DONE.
- Arithmetic:
  - Full unsigned WIDTH x WIDTH -> 2*WIDTH product, no truncation, no overflow flag.
  - Operands are captured at acceptance; later changes on op_a/op_b have no effect.
- Operand of zero still takes the full WIDTH cycles; no early termination.
- hi/lo change only on commit or reset.

Test Plan:
- Reset then start with op_a=3, op_b=5 -> busy=1 for 32 cycles; done pulses once in cycle 33; hi=0x00000000, lo=0x0000000F; busy=0 after.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (carry path exercised).
- Start with 7*9, then assert rd_hilo at cycle 5 and hold -> stall=1 through cycle 32, stall=0 in DONE cycle; lo reads 0x0000003F, hi=0.
- Back-to-back: start 0x10000*0x10000, hold start during RUN -> second operation (same or new operands, e.g. 2*4) accepted in DONE cycle; first result hi=0x00000001, lo=0; second lo=0x00000008 after a further 32 cycles; no lost or duplicated done pulses.
- Start 0x1234*0x5678, drop rst low at cycle 10 for 1 cycle -> hi=lo=0, busy=0, done never pulses; a subsequent 2*3 yields lo=6.
- Change op_a/op_b every cycle during RUN after starting 100*200 -> lo=0x00004E20 (20000), proving operand capture.
